// File: rtl/pwmout_pkg.sv
// Shared state encoding and 33-bit signed helpers for the pwmout sequencer.
package pwmout_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE      = 2'd0,
        SEQ_RUN       = 2'd1,
        SEQ_ZERO_HOLD = 2'd2,
        SEQ_FAULT     = 2'd3
    } seq_state_e;

    function automatic logic signed [32:0] clamp33(input logic signed [32:0] v,
                                                   input logic signed [32:0] lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // One slew step from cur toward goal, never overshooting goal.
    function automatic logic signed [32:0] step33(input logic signed [32:0] cur,
                                                  input logic signed [32:0] goal,
                                                  input logic signed [32:0] step);
        logic signed [32:0] diff;
        diff = goal - cur;
        if (diff > step)  return cur + step;
        if (diff < -step) return cur - step;
        return goal;
    endfunction

endpackage

// File: rtl/pwmout_period_timer.sv
// Free-running 0..DIVIDER counter; period_tick marks the last count of each period.
module pwmout_period_timer #(
    parameter int DIVIDER = 255
) (
    input  logic clk,
    input  logic rst_n,
    output logic period_tick
);
    localparam int CW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign period_tick = (cnt_q == LAST);

endmodule

// File: rtl/pwmout_sequencer.sv
// Duty/enable sequencer for one pwmout generator: clamped target, per-period slew,
// zero-crossing dead time on reversal and a command watchdog.
module pwmout_sequencer
    import pwmout_pkg::*;
#(
    parameter int DIVIDER     = 255,
    parameter int STEP        = 4,
    parameter int DEADTIME    = 2,
    parameter int WDT_PERIODS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cmd_dty,
    input  logic        cmd_valid,
    input  logic        cmd_enable,
    input  logic        fault_clr,
    output logic [31:0] dty,
    output logic        enable,
    output logic        period_tick,
    output logic [1:0]  state,
    output logic        at_target,
    output logic        fault
);
    localparam logic signed [32:0] LIM  = 33'(DIVIDER);
    localparam logic signed [32:0] STP  = 33'(STEP);
    localparam logic [31:0]        WDT  = 32'(WDT_PERIODS);
    localparam logic [31:0]        HOLD = 32'(DEADTIME);

    seq_state_e  state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] dty_q, dty_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] wdt_q, wdt_d;

    logic signed [32:0] eff33, dty33, slew_goal, slew_nxt;
    logic               opposite, wdt_live, expire;

    pwmout_period_timer #(.DIVIDER(DIVIDER)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .period_tick(period_tick)
    );

    always_comb begin
        eff33     = cmd_enable ? {target_q[31], target_q} : 33'sd0;
        dty33     = {dty_q[31], dty_q};
        opposite  = ((eff33 > 33'sd0) && (dty33 < 33'sd0)) ||
                    ((eff33 < 33'sd0) && (dty33 > 33'sd0));
        // A reversal first unwinds to zero; the new direction starts after the hold.
        slew_goal = opposite ? 33'sd0 : eff33;
        slew_nxt  = step33(dty33, slew_goal, STP);
        wdt_live  = (state_q == SEQ_RUN) || (state_q == SEQ_ZERO_HOLD);
        expire    = wdt_live && (WDT_PERIODS != 0) && (wdt_q >= WDT);
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dty_d    = dty_q;
        hold_d   = hold_q;
        wdt_d    = wdt_q;

        if (cmd_valid)
            target_d = 32'(clamp33({cmd_dty[31], cmd_dty}, LIM));

        if (!wdt_live || cmd_valid)
            wdt_d = '0;
        else if (period_tick && (wdt_q < WDT))
            wdt_d = wdt_q + 32'd1;

        // A command arriving in the expiry cycle counts as a kick and suppresses the fault.
        if (expire && !cmd_valid) begin
            state_d  = SEQ_FAULT;
            target_d = '0;
            dty_d    = '0;
            hold_d   = '0;
            wdt_d    = '0;
        end else if (period_tick) begin
            case (state_q)
                SEQ_IDLE: begin
                    dty_d = '0;
                    if (cmd_enable) state_d = SEQ_RUN;
                end
                SEQ_RUN: begin
                    dty_d = slew_nxt[31:0];
                    if (opposite && (slew_nxt == 33'sd0) && (DEADTIME > 0)) begin
                        state_d = SEQ_ZERO_HOLD;
                        hold_d  = HOLD;
                    end else if (!cmd_enable && (slew_nxt == 33'sd0)) begin
                        state_d = SEQ_IDLE;
                    end
                end
                SEQ_ZERO_HOLD: begin
                    dty_d = '0;
                    if (!cmd_enable) begin
                        state_d = SEQ_IDLE;
                        hold_d  = '0;
                    end else if (hold_q <= 32'd1) begin
                        state_d = SEQ_RUN;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q - 32'd1;
                    end
                end
                SEQ_FAULT: begin
                    dty_d = '0;
                    if (fault_clr && !cmd_enable) begin
                        state_d  = SEQ_IDLE;
                        target_d = '0;
                    end
                end
                default: state_d = SEQ_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= SEQ_IDLE;
            target_q <= '0;
            dty_q    <= '0;
            hold_q   <= '0;
            wdt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            dty_q    <= dty_d;
            hold_q   <= hold_d;
            wdt_q    <= wdt_d;
        end
    end

    assign dty       = dty_q;
    assign state     = state_q;
    assign enable    = (state_q == SEQ_RUN) || (state_q == SEQ_ZERO_HOLD);
    assign fault     = (state_q == SEQ_FAULT);
    assign at_target = (state_q != SEQ_FAULT) && (dty33 == eff33);

endmodule

// File: tb/tb_pwmout_sequencer.sv
// Bench for pwmout_sequencer: tick-level vector table, hand-written corner sequences
// and randomized traffic checked cycle by cycle against a reference model.
module tb_pwmout_sequencer;
    localparam int DIV = 15;
    localparam int STP = 4;
    localparam int DT  = 2;
    localparam int WDT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cmd_dty = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_enable = 1'b0;
    logic        fault_clr = 1'b0;
    logic [31:0] dty;
    logic        enable, period_tick, at_target, fault;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;

    // reference model: state code 0..3, duty and target as plain integers
    int     m_st, m_hold, m_wdt, m_cnt;
    longint m_tgt, m_dty;

    pwmout_sequencer #(.DIVIDER(DIV), .STEP(STP), .DEADTIME(DT), .WDT_PERIODS(WDT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_dty    (cmd_dty),
        .cmd_valid  (cmd_valid),
        .cmd_enable (cmd_enable),
        .fault_clr  (fault_clr),
        .dty        (dty),
        .enable     (enable),
        .period_tick(period_tick),
        .state      (state),
        .at_target  (at_target),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_cmd;
        logic [31:0] cmd;
        int          exp_dty;
        int          exp_st;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint clampf(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s > DIV)  return DIV;
        if (s < -DIV) return -DIV;
        return s;
    endfunction

    task automatic model_reset();
        m_st = 0; m_hold = 0; m_wdt = 0; m_cnt = 0; m_tgt = 0; m_dty = 0;
    endtask

    task automatic model_step();
        bit     tk, live, rev;
        longint eff, nt, goal, d, mv;
        tk   = (m_cnt == DIV);
        eff  = cmd_enable ? m_tgt : 0;
        live = (m_st == 1) || (m_st == 2);
        if (live && m_wdt >= WDT && !cmd_valid) begin
            m_st = 3; m_dty = 0; m_tgt = 0; m_hold = 0; m_wdt = 0;
        end else begin
            nt = cmd_valid ? clampf(cmd_dty) : m_tgt;
            if (!live || cmd_valid) m_wdt = 0;
            else if (tk && m_wdt < WDT) m_wdt++;
            if (tk) begin
                case (m_st)
                    0: if (cmd_enable) m_st = 1;
                    1: begin
                        rev  = (eff * m_dty) < 0;
                        goal = rev ? 0 : eff;
                        d    = goal - m_dty;
                        mv   = (d < 0) ? -d : d;
                        if (mv > STP) mv = STP;
                        m_dty = m_dty + ((d > 0) ? mv : -mv);
                        if (rev && m_dty == 0 && DT > 0) begin
                            m_st = 2; m_hold = DT;
                        end else if (!cmd_enable && m_dty == 0) begin
                            m_st = 0;
                        end
                    end
                    2: begin
                        if (!cmd_enable) begin
                            m_st = 0; m_hold = 0;
                        end else begin
                            m_hold--;
                            if (m_hold == 0) m_st = 1;
                        end
                    end
                    default: if (fault_clr && !cmd_enable) begin
                        m_st = 0; nt = 0;
                    end
                endcase
            end
            m_tgt = nt;
        end
        m_cnt = tk ? 0 : m_cnt + 1;
    endtask

    // One clock: check outputs against the model, advance the model, move to next negedge.
    task automatic cyc();
        longint eff;
        bit     e_at, e_en, e_tk, e_ft;
        #1;
        eff  = cmd_enable ? m_tgt : 0;
        e_at = (m_st != 3) && (m_dty == eff);
        e_en = (m_st == 1) || (m_st == 2);
        e_tk = (m_cnt == DIV);
        e_ft = (m_st == 3);
        total++;
        if (longint'($signed(dty)) != m_dty || enable != e_en || period_tick != e_tk ||
            int'(state) != m_st || at_target != e_at || fault != e_ft) begin
            bad++;
            $display("FAIL model t=%0t: dty %0d/%0d en %0b/%0b tick %0b/%0b st %0d/%0d at %0b/%0b flt %0b/%0b (got/want)",
                     $time, $signed(dty), m_dty, enable, e_en, period_tick, e_tk,
                     state, m_st, at_target, e_at, fault, e_ft);
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        bit tk;
        for (int i = 0; i < 40; i++) begin
            tk = (m_cnt == DIV);
            cyc();
            if (tk) return;
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic pulse_cmd(input logic [31:0] v);
        cmd_dty = v; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit quiet;
        tbl[0]  = '{1, 32'd10,         0, 1};
        tbl[1]  = '{0, 32'd0,          4, 1};
        tbl[2]  = '{0, 32'd0,          8, 1};
        tbl[3]  = '{0, 32'd0,         10, 1};
        tbl[4]  = '{1, -32'sd6,        6, 1};
        tbl[5]  = '{0, 32'd0,          2, 1};
        tbl[6]  = '{0, 32'd0,          0, 2};
        tbl[7]  = '{0, 32'd0,          0, 2};
        tbl[8]  = '{0, 32'd0,          0, 1};
        tbl[9]  = '{0, 32'd0,         -4, 1};
        tbl[10] = '{0, 32'd0,         -6, 1};
        tbl[11] = '{1, 32'd1000,      -2, 1};
        tbl[12] = '{0, 32'd0,          0, 2};
        tbl[13] = '{0, 32'd0,          0, 2};
        tbl[14] = '{0, 32'd0,          0, 1};
        tbl[15] = '{0, 32'd0,          4, 1};
        tbl[16] = '{1, 32'd1000,       8, 1};
        tbl[17] = '{0, 32'd0,         12, 1};
        tbl[18] = '{0, 32'd0,         15, 1};
        tbl[19] = '{1, 32'h8000_0000, 11, 1};
        tbl[20] = '{0, 32'd0,          7, 1};
        tbl[21] = '{0, 32'd0,          3, 1};
        tbl[22] = '{0, 32'd0,          0, 2};
        tbl[23] = '{0, 32'd0,          0, 2};
        tbl[24] = '{0, 32'd0,          0, 1};
        tbl[25] = '{1, 32'h8000_0000, -4, 1};
        tbl[26] = '{0, 32'd0,         -8, 1};
        tbl[27] = '{0, 32'd0,        -12, 1};
        tbl[28] = '{0, 32'd0,        -15, 1};

        // reset state
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_dty", longint'($signed(dty)), 0);
        chk("rst_enable", enable, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_state", state, 0);
        chk("rst_fault", fault, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ramp, reversal through zero hold, clamping
        cmd_enable = 1'b1;
        for (int i = 0; i < 29; i++) begin
            if (tbl[i].do_cmd) pulse_cmd(tbl[i].cmd);
            wait_tick();
            chk($sformatf("vec%0d_dty", i), longint'($signed(dty)), tbl[i].exp_dty);
            chk($sformatf("vec%0d_state", i), state, tbl[i].exp_st);
            if (i == 0) chk("vec0_enable", enable, 1);
            if (i == 3) chk("vec3_at_target", at_target, 1);
        end
        chk("sat_at_target", at_target, 1);

        // watchdog expiry and fault clearing
        pulse_cmd(32'h8000_0000);
        repeat (7) wait_tick();
        chk("wdt_pre_state", state, 1);
        wait_tick();
        chk("wdt_expiry_cycle_state", state, 1);
        cyc();
        chk("fault_state", state, 3);
        chk("fault_dty", longint'($signed(dty)), 0);
        chk("fault_enable", enable, 0);
        chk("fault_flag", fault, 1);
        chk("fault_at_target", at_target, 0);
        pulse_cmd(32'd9);
        fault_clr = 1'b1;
        repeat (2) wait_tick();
        chk("fault_clr_en1_state", state, 3);
        cmd_enable = 1'b0;
        wait_tick();
        chk("fault_clr_state", state, 0);
        chk("fault_clr_flag", fault, 0);
        fault_clr = 1'b0;
        cmd_enable = 1'b1;
        wait_tick();
        chk("post_fault_run", state, 1);
        wait_tick();
        chk("post_fault_target0", longint'($signed(dty)), 0);
        chk("post_fault_at_target", at_target, 1);

        // command on the tick cycle applies from the following tick
        for (int i = 0; i < 40 && m_cnt != DIV; i++) cyc();
        cmd_dty = 32'd8; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("tick_cmd_old_target", longint'($signed(dty)), 0);
        wait_tick();
        chk("tick_cmd_new_target", longint'($signed(dty)), 4);
        wait_tick();
        repeat (6) wait_tick();
        chk("expiry_pending_state", state, 1);
        pulse_cmd(32'd8);
        repeat (3) cyc();
        chk("expiry_kick_state", state, 1);
        chk("expiry_kick_fault", fault, 0);

        // asynchronous reset mid-ramp
        apply_reset();
        pulse_cmd(32'd15);
        wait_tick();
        wait_tick();
        wait_tick();
        chk("midramp_dty", longint'($signed(dty)), 8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dty", longint'($signed(dty)), 0);
        chk("async_rst_enable", enable, 0);
        chk("async_rst_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        wait_tick();
        chk("resume_state", state, 1);
        wait_tick();
        chk("resume_dty0", longint'($signed(dty)), 0);
        pulse_cmd(32'd15);
        wait_tick();
        chk("resume_ramp", longint'($signed(dty)), 4);

        // randomized traffic against the model
        apply_reset();
        quiet = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) cmd_enable = ~cmd_enable;
            if ($urandom_range(0, 299) == 0) quiet = ~quiet;
            cmd_valid = !quiet && ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       cmd_dty = $urandom;
                1:       cmd_dty = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7fff_ffff;
                default: cmd_dty = 32'($urandom_range(0, 40)) - 32'd20;
            endcase
            fault_clr = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
